// File: rtl/icache_fetch_responder_if.sv
// Fetch-side and refill-bus signals of the instruction cache.
// The cache itself connects through the slave modport.
interface icache_fetch_responder_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] pc;
  logic              flush;
  logic              hit;
  logic [DATA_W-1:0] instr;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  pc, flush, mem_ack, mem_rdata,
    output hit, instr, mem_req, mem_addr
  );

  modport master (
    output pc, flush, mem_ack, mem_rdata,
    input  hit, instr, mem_req, mem_addr
  );
endinterface

// File: rtl/icache_fetch_responder.sv
// Direct-mapped instruction cache feeding the PC register.
// Lookup is combinational; a miss refills one line in beat order over req/ack.
module icache_fetch_responder #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LINES  = 16,
  parameter int WORDS  = 4
) (
  input logic                   clk,
  input logic                   rstn,
  icache_fetch_responder_if.slave bus
);
  localparam int IDX_W  = $clog2(LINES);
  localparam int WORD_W = $clog2(WORDS);
  localparam int TAG_W  = ADDR_W - 2 - WORD_W - IDX_W;

  typedef enum logic {IDLE, REFILL} state_t;

  state_t             state;
  logic [LINES-1:0]   valid;
  logic [TAG_W-1:0]   tag_arr [LINES];
  logic [DATA_W-1:0]  data_arr [LINES][WORDS];
  logic [TAG_W-1:0]   ref_tag;
  logic [IDX_W-1:0]   ref_idx;
  logic [WORD_W-1:0]  beat;
  logic               flush_pend;
  logic               mem_req_q;
  logic [ADDR_W-1:0]  mem_addr_q;

  logic [WORD_W-1:0]  word;
  logic [IDX_W-1:0]   idx;
  logic [TAG_W-1:0]   tag;
  logic               lookup_hit;
  logic               last_beat;

  assign word = bus.pc[2 +: WORD_W];
  assign idx  = bus.pc[2 + WORD_W +: IDX_W];
  assign tag  = bus.pc[ADDR_W-1 -: TAG_W];

  // A flush in IDLE suppresses the hit so the PC cannot advance on a line being invalidated
  assign lookup_hit = (state == IDLE) && !bus.flush && valid[idx] && (tag_arr[idx] == tag);
  assign last_beat  = (beat == WORD_W'(WORDS - 1));

  assign bus.hit      = lookup_hit;
  assign bus.instr    = lookup_hit ? data_arr[idx][word] : '0;
  assign bus.mem_req  = mem_req_q;
  assign bus.mem_addr = mem_addr_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      valid      <= '0;
      ref_tag    <= '0;
      ref_idx    <= '0;
      beat       <= '0;
      flush_pend <= 1'b0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.flush) begin
            valid <= '0;
          end else if (!lookup_hit) begin
            ref_tag    <= tag;
            ref_idx    <= idx;
            beat       <= '0;
            mem_req_q  <= 1'b1;
            mem_addr_q <= {tag, idx, {(WORD_W + 2){1'b0}}};
            state      <= REFILL;
          end
        end
        REFILL: begin
          if (bus.flush) flush_pend <= 1'b1;
          if (bus.mem_ack) begin
            beat       <= beat + 1'b1;
            mem_addr_q <= mem_addr_q + ADDR_W'(4);
            if (last_beat) begin
              mem_req_q  <= 1'b0;
              flush_pend <= 1'b0;
              state      <= IDLE;
              // A flush seen at any point of the refill also drops the line just filled
              if (flush_pend || bus.flush) valid <= '0;
              else                         valid[ref_idx] <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state == REFILL && bus.mem_ack) begin
      data_arr[ref_idx][beat] <= bus.mem_rdata;
      if (last_beat) tag_arr[ref_idx] <= ref_tag;
    end
  end
endmodule

// File: tb/tb_icache_fetch_responder.sv
// Directed bench for icache_fetch_responder with a queue scoreboard for
// refill beat addresses and expected instruction words.
module tb_icache_fetch_responder;
  logic clk = 1'b0;
  logic rstn;
  int   n_cmp = 0;
  int   n_bad = 0;

  logic [31:0] exp_q [$];
  logic [31:0] mem_model [logic [31:0]];

  icache_fetch_responder_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  icache_fetch_responder #(.ADDR_W(32), .DATA_W(32), .LINES(16), .WORDS(4)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    if (mem_model.exists(addr)) return mem_model[addr];
    return addr ^ 32'hDEAD_0000;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive pc and compare the same-cycle lookup against the bench's memory image
  task automatic lookup(input logic [31:0] addr, input bit expect_hit);
    logic [31:0] exp;
    bus.pc = addr;
    #1;
    exp_q.push_back(expect_hit ? mem_word({addr[31:2], 2'b00}) : 32'h0);
    exp = exp_q.pop_front();
    check($sformatf("hit@%h", addr), 32'(bus.hit), 32'(expect_hit));
    check($sformatf("instr@%h", addr), bus.instr, exp);
  endtask

  // Answer a refill starting at the current negedge; returns at the negedge after the last ack
  task automatic serve(input logic [31:0] base, input int gaps, input int beats,
                       input int flush_beat, input logic [31:0] alt_pc);
    logic [31:0] exp;
    for (int b = 0; b < beats; b++) begin
      exp_q.push_back(base + 32'(4 * b));
      for (int g = 0; g < gaps; g++) begin
        check("gap_req", 32'(bus.mem_req), 32'h1);
        check("gap_addr", bus.mem_addr, exp_q[0]);
        check("gap_hit", 32'(bus.hit), 32'h0);
        bus.pc = (g % 2 == 0) ? alt_pc : base;
        @(negedge clk);
      end
      bus.pc = base;
      #1;
      exp = exp_q.pop_front();
      check($sformatf("beat%0d_addr", b), bus.mem_addr, exp);
      check($sformatf("beat%0d_req", b), 32'(bus.mem_req), 32'h1);
      check($sformatf("beat%0d_hit", b), 32'(bus.hit), 32'h0);
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = mem_word(exp);
      bus.flush     = (b == flush_beat);
      @(negedge clk);
      bus.mem_ack   = 1'b0;
      bus.mem_rdata = '0;
      bus.flush     = 1'b0;
    end
  endtask

  task automatic expect_refill_start(input logic [31:0] base);
    @(negedge clk);
    check("start_req", 32'(bus.mem_req), 32'h1);
    check("start_addr", bus.mem_addr, base);
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      mem_model[32'h0 + 32'(4 * i)]   = 32'h11 * 32'(i + 1);
      mem_model[32'h100 + 32'(4 * i)] = 32'hA0 + 32'(i);
    end

    rstn = 1'b0;
    bus.pc = '0; bus.flush = 1'b0; bus.mem_ack = 1'b0; bus.mem_rdata = '0;
    repeat (2) @(negedge clk);
    check("rst_req", 32'(bus.mem_req), 32'h0);
    check("rst_addr", bus.mem_addr, 32'h0);
    rstn = 1'b1;

    // Cold miss at pc 0 and first refill
    lookup(32'h0, 1'b0);
    expect_refill_start(32'h0);
    serve(32'h0, 0, 4, -1, 32'h0);
    check("t2_req_drop", 32'(bus.mem_req), 32'h0);
    lookup(32'h0, 1'b1);
    lookup(32'h8, 1'b1);

    // Conflict eviction on index 0
    @(negedge clk);
    lookup(32'h100, 1'b0);
    expect_refill_start(32'h100);
    serve(32'h100, 0, 4, -1, 32'h0);
    lookup(32'h100, 1'b1);
    lookup(32'h0, 1'b0);
    expect_refill_start(32'h0);
    serve(32'h0, 0, 4, -1, 32'h0);
    lookup(32'h4, 1'b1);

    // Slow memory with pc wandering during the refill
    @(negedge clk);
    lookup(32'h40, 1'b0);
    expect_refill_start(32'h40);
    serve(32'h40, 3, 4, -1, 32'h80);
    check("t4_req_drop", 32'(bus.mem_req), 32'h0);
    lookup(32'h44, 1'b1);
    lookup(32'h80, 1'b0);
    expect_refill_start(32'h80);
    serve(32'h80, 0, 4, -1, 32'h0);
    lookup(32'h8C, 1'b1);
    lookup(32'h40, 1'b1);

    // Flush during refill beat 2
    @(negedge clk);
    lookup(32'hC0, 1'b0);
    expect_refill_start(32'hC0);
    serve(32'hC0, 0, 4, 2, 32'h0);
    lookup(32'hC0, 1'b0);
    expect_refill_start(32'hC0);
    serve(32'hC0, 0, 4, -1, 32'h0);
    lookup(32'hC4, 1'b1);

    // Flush while idle on a hitting pc
    @(negedge clk);
    bus.pc = 32'hC0;
    bus.flush = 1'b1;
    #1;
    check("idle_flush_hit", 32'(bus.hit), 32'h0);
    @(negedge clk);
    bus.flush = 1'b0;
    #1;
    check("idle_flush_noreq", 32'(bus.mem_req), 32'h0);
    check("idle_flush_miss", 32'(bus.hit), 32'h0);
    expect_refill_start(32'hC0);
    serve(32'hC0, 0, 4, -1, 32'h0);
    lookup(32'hC8, 1'b1);

    // Stray ack while idle
    @(negedge clk);
    bus.mem_ack = 1'b1;
    @(negedge clk);
    bus.mem_ack = 1'b0;
    check("stray_ack_req", 32'(bus.mem_req), 32'h0);
    lookup(32'hC8, 1'b1);

    // Reset in the middle of a refill
    @(negedge clk);
    lookup(32'h200, 1'b0);
    expect_refill_start(32'h200);
    serve(32'h200, 0, 2, -1, 32'h0);
    rstn = 1'b0;
    #1;
    check("mid_rst_req", 32'(bus.mem_req), 32'h0);
    @(negedge clk);
    rstn = 1'b1;
    lookup(32'h200, 1'b0);
    expect_refill_start(32'h200);
    serve(32'h200, 0, 4, -1, 32'h0);
    lookup(32'h20C, 1'b1);
    lookup(32'h0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
